// File: rtl/frame_reader_pkg.sv
// Shared definitions for the frame reader: default geometry, field widths,
// FSM state encoding and the beat carried through the output buffer.
package frame_reader_pkg;

    localparam int unsigned DEF_NUM_SOLVERS = 1;
    localparam int unsigned DEF_NUM_COLUMNS = 640;
    localparam int unsigned DEF_NUM_ROWS    = 480;

    localparam int unsigned COL_W  = 10;
    localparam int unsigned ROW_W  = 9;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned SID_W  = 6;
    localparam int unsigned DATA_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StScan,
        StDrain
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [COL_W-1:0]  col;
        logic [ROW_W-1:0]  row;
        logic              last;
    } beat_t;

    // Negative two's-complement samples are forced to zero.
    function automatic logic [DATA_W-1:0] clamp_data(input logic [DATA_W-1:0] d);
        return d[DATA_W-1] ? '0 : d;
    endfunction

endpackage

// File: rtl/frame_reader_skid.sv
// Two-entry valid/ready buffer. The producer is expected to track count_o
// and never push into a full buffer that is not draining this cycle.
module frame_reader_skid #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] head_q, head_d;
    logic [Width-1:0] tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             pop;

    assign pop         = (cnt_q != 2'd0) && out_ready_i;
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = head_q;
    assign count_o     = cnt_q;

    // Next-state for the head/tail entries; head is always the presented beat.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        unique case ({in_valid_i, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = in_data_i;
                else               tail_d = in_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = in_data_i;
                end else begin
                    head_d = in_data_i;
                end
            end
            default: ;
        endcase
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_reader.sv
// Frame reader: once solvers finish, scans the frame in raster order, reads
// each pixel from bank (p mod NUM_SOLVERS) at word (p div NUM_SOLVERS) using
// incremental counters, and streams the results over valid/ready.
// Build option: define FRAME_READER_CLAMP_EN to emit negative samples as zero.
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter int unsigned NUM_SOLVERS = DEF_NUM_SOLVERS,
    parameter int unsigned NUM_COLUMNS = DEF_NUM_COLUMNS,
    parameter int unsigned NUM_ROWS    = DEF_NUM_ROWS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              solve_done_i,
    output logic [SID_W-1:0]  rd_solver_id_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              pix_valid_o,
    input  logic              pix_ready_i,
    output logic [DATA_W-1:0] pix_data_o,
    output logic [COL_W-1:0]  pix_col_o,
    output logic [ROW_W-1:0]  pix_row_o,
    output logic              pix_last_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam logic [COL_W-1:0] ColLast = COL_W'(NUM_COLUMNS - 1);
    localparam logic [ROW_W-1:0] RowLast = ROW_W'(NUM_ROWS - 1);
    localparam logic [SID_W-1:0] SidLast = SID_W'(NUM_SOLVERS - 1);

    state_e            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [SID_W-1:0]  sid_q, sid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q;
    logic [COL_W-1:0]  tag_col_q;
    logic [ROW_W-1:0]  tag_row_q;
    logic              tag_last_q;
    logic              frame_done_q;

    logic              issue;
    logic              last_pix;
    logic              accept;
    logic [1:0]        skid_cnt;
    logic [2:0]        credit_used;
    logic [DATA_W-1:0] data_eff;
    beat_t             in_beat;
    beat_t             out_beat;

    assign last_pix = (col_q == ColLast) && (row_q == RowLast);
    assign accept   = pix_valid_o && pix_ready_i;
    // A beat leaving this cycle frees its slot, which keeps the pipe at 1 pixel/cycle.
    assign credit_used = 3'(skid_cnt) - 3'(accept) + 3'(inflight_q);

    // Control FSM and read-issue decision.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StWait;
            StWait:  if (solve_done_i) state_d = StScan;
            StScan: begin
                if (credit_used < 3'd2) begin
                    issue = 1'b1;
                    if (last_pix) state_d = StDrain;
                end
            end
            StDrain: if (skid_cnt == 2'd0 && !inflight_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Raster and bank/word counters; cleared when a new frame is armed.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        sid_d  = sid_q;
        addr_d = addr_q;
        if (state_q == StIdle && start_i) begin
            col_d  = '0;
            row_d  = '0;
            sid_d  = '0;
            addr_d = '0;
        end else if (issue) begin
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (sid_q == SidLast) begin
                sid_d  = '0;
                addr_d = addr_q + 1'b1;
            end else begin
                sid_d = sid_q + 1'b1;
            end
        end
    end

    // State, counters, and the tag that travels with the outstanding read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            col_q        <= '0;
            row_q        <= '0;
            sid_q        <= '0;
            addr_q       <= '0;
            inflight_q   <= 1'b0;
            tag_col_q    <= '0;
            tag_row_q    <= '0;
            tag_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            sid_q        <= sid_d;
            addr_q       <= addr_d;
            inflight_q   <= issue;
            frame_done_q <= accept && pix_last_o;
            if (issue) begin
                tag_col_q  <= col_q;
                tag_row_q  <= row_q;
                tag_last_q <= last_pix;
            end
        end
    end

`ifdef FRAME_READER_CLAMP_EN
    assign data_eff = clamp_data(rd_data_i);
`else
    assign data_eff = rd_data_i;
`endif

    assign in_beat = '{data: data_eff, col: tag_col_q, row: tag_row_q, last: tag_last_q};

    frame_reader_skid #(
        .Width($bits(beat_t))
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (inflight_q),
        .in_data_i   (in_beat),
        .out_valid_o (pix_valid_o),
        .out_ready_i (pix_ready_i),
        .out_data_o  (out_beat),
        .count_o     (skid_cnt)
    );

    assign rd_solver_id_o = sid_q;
    assign rd_addr_o      = addr_q;
    assign pix_data_o     = out_beat.data;
    assign pix_col_o      = out_beat.col;
    assign pix_row_o      = out_beat.row;
    assign pix_last_o     = out_beat.last;
    assign busy_o         = (state_q != StIdle);
    assign frame_done_o   = frame_done_q;

endmodule

// File: tb/tb_frame_reader.sv
// Randomized bench for frame_reader: a RAM model with random contents and a
// pixel-index reference model that derives bank, word, coordinates and last
// flag from plain division/modulo of the raster index.
module tb_frame_reader;
    import frame_reader_pkg::*;

    localparam int unsigned NS    = 3;
    localparam int unsigned NC    = 5;
    localparam int unsigned NR    = 3;
    localparam int unsigned NPIX  = NC * NR;
    localparam int unsigned WORDS = (NPIX + NS - 1) / NS;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              solve_done;
    logic [SID_W-1:0]  rd_sid;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic              pix_valid;
    logic              pix_ready = 1'b1;
    logic [DATA_W-1:0] pix_data;
    logic [COL_W-1:0]  pix_col;
    logic [ROW_W-1:0]  pix_row;
    logic              pix_last;
    logic              busy;
    logic              frame_done;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned exp_idx  = 0;
    int unsigned n_done   = 0;
    int unsigned rdy_mode = 0;
    bit          last_acc = 1'b0;
    bit          hold     = 1'b0;
    logic [31:0] held_beat;

    logic [DATA_W-1:0] ram [64][64];

    always #5 clk = ~clk;

    frame_reader #(
        .NUM_SOLVERS (NS),
        .NUM_COLUMNS (NC),
        .NUM_ROWS    (NR)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .solve_done_i   (solve_done),
        .rd_solver_id_o (rd_sid),
        .rd_addr_o      (rd_addr),
        .rd_data_i      (rd_data),
        .pix_valid_o    (pix_valid),
        .pix_ready_i    (pix_ready),
        .pix_data_o     (pix_data),
        .pix_col_o      (pix_col),
        .pix_row_o      (pix_row),
        .pix_last_o     (pix_last),
        .busy_o         (busy),
        .frame_done_o   (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_data(input int unsigned p);
        logic [DATA_W-1:0] d;
        d = ram[p % NS][p / NS];
`ifdef FRAME_READER_CLAMP_EN
        if (d[DATA_W-1]) d = '0;
`endif
        return d;
    endfunction

    // Synchronous RAM: data for the address seen at an edge is valid the next cycle.
    always @(posedge clk) rd_data <= ram[rd_sid][rd_addr[5:0]];

    // Downstream ready: held high or toggled pseudo-randomly.
    always @(posedge clk) begin
        #1;
        pix_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // Output monitor: ordering, content, hold-while-stalled and frame_done timing.
    always @(negedge clk) begin
        if (!rst) begin
            if (hold) begin
                check("hold_valid", 32'(pix_valid), 32'd1);
                check("hold_beat", 32'({pix_data, pix_col, pix_row, pix_last}), held_beat);
            end
            if (frame_done || last_acc) check("frame_done", 32'(frame_done), 32'(last_acc));
            if (frame_done) n_done++;
            last_acc = 1'b0;
            hold     = 1'b0;
            if (pix_valid && pix_ready) begin
                check("beat_in_frame", 32'(exp_idx < NPIX), 32'd1);
                check("pix_data", 32'(pix_data), 32'(exp_data(exp_idx)));
                check("pix_col", 32'(pix_col), exp_idx % NC);
                check("pix_row", 32'(pix_row), exp_idx / NC);
                check("pix_last", 32'(pix_last), 32'(exp_idx == NPIX - 1));
                if (pix_last) last_acc = 1'b1;
                exp_idx++;
            end else if (pix_valid) begin
                hold      = 1'b1;
                held_beat = 32'({pix_data, pix_col, pix_row, pix_last});
            end
        end
    end

    task automatic fill_ram();
        for (int s = 0; s < int'(NS); s++)
            for (int a = 0; a < int'(WORDS); a++)
                ram[s][a] = 4'($urandom_range(0, 15));
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // One full frame; hold_off > 0 keeps solve_done low that many cycles after start.
    task automatic run_frame(input int unsigned hold_off);
        int unsigned cyc;
        fill_ram();
        exp_idx    = 0;
        n_done     = 0;
        solve_done = (hold_off == 0);
        pulse_start();
        if (hold_off != 0) begin
            repeat (hold_off) @(posedge clk);
            #1;
            check("wait_no_valid", 32'(pix_valid), 32'd0);
            check("wait_busy", 32'(busy), 32'd1);
            check("wait_rd_addr", 32'(rd_addr), 32'd0);
            check("wait_rd_sid", 32'(rd_sid), 32'd0);
            solve_done = 1'b1;
            // SCAN one edge after solve_done is seen, valid two cycles later: 4th negedge.
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!pix_valid && cyc < 10);
            check("first_valid_latency", cyc, 32'd4);
        end
        cyc = 0;
        while (n_done == 0 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("frame_done_count", n_done, 32'd1);
        check("pixel_count", exp_idx, NPIX);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(pix_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned cyc;
        rst        = 1'b1;
        start      = 1'b0;
        solve_done = 1'b0;
        for (int s = 0; s < 64; s++)
            for (int a = 0; a < 64; a++)
                ram[s][a] = '0;
        #12;
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_rd_sid", 32'(rd_sid), 32'd0);
        check("rst_beat", 32'({pix_data, pix_col, pix_row, pix_last}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Ready held high, solve_done already high.
        rdy_mode = 0;
        run_frame(0);

        // Solve still running for 20 cycles after start.
        run_frame(20);

        // Random backpressure over several frames.
        rdy_mode = 1;
        for (int f = 0; f < 4; f++) run_frame(0);

        // Abort mid-scan, then a clean frame from pixel 0.
        rdy_mode = 0;
        fill_ram();
        exp_idx    = 0;
        n_done     = 0;
        solve_done = 1'b1;
        pulse_start();
        cyc = 0;
        while (exp_idx < 3 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        check("reached_pixel3", 32'(exp_idx >= 3), 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_valid", 32'(pix_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_addr", 32'(rd_addr), 32'd0);
        check("abort_rd_sid", 32'(rd_sid), 32'd0);
        check("abort_beat", 32'({pix_data, pix_col, pix_row, pix_last}), 32'd0);
        check("abort_no_done", n_done, 32'd0);
        last_acc = 1'b0;
        hold     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_frame(0);

        rdy_mode = 1;
        run_frame(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
